// File: rtl/ad9643_ddr_deinterleave_if.sv
// AD9643 DDR deinterleaver bus: captured DDR words and host train level in,
// aligned A/B sample pairs plus training status out.
// master drives the ADC words and train; slave is the deinterleaver.
interface ad9643_ddr_deinterleave_if #(
  parameter int W = 14
);
  logic [W-1:0] din_rise;
  logic [W-1:0] din_fall;
  logic         train;
  logic [W-1:0] dout_a;
  logic [W-1:0] dout_b;
  logic         dout_valid;
  logic         locked;
  logic         swapped;
  logic         train_fail;
  logic [15:0]  err_count;

  modport master (
    output din_rise, din_fall, train,
    input  dout_a, dout_b, dout_valid, locked, swapped, train_fail, err_count
  );

  modport slave (
    input  din_rise, din_fall, train,
    output dout_a, dout_b, dout_valid, locked, swapped, train_fail, err_count
  );
endinterface

// File: rtl/ad9643_ddr_deinterleave.sv
// Splits the AD9643 DDR rise/fall word stream into channel A/B samples after
// a pattern-based training phase that decides whether rise and fall are swapped.
// Latency: 1 cycle input pair to dout once locked; no backpressure (ADC stream).
module ad9643_ddr_deinterleave #(
  parameter int           W          = 14,
  parameter logic [W-1:0] PAT_A      = 14'h2AAA,
  parameter logic [W-1:0] PAT_B      = 14'h1555,
  parameter int           LOCK_COUNT = 64,
  parameter int           TIMEOUT    = 4096
) (
  input logic clk,
  input logic rst_n,
  ad9643_ddr_deinterleave_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRAIN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] FAIL   = 2'd3;

  logic [1:0]    state;
  logic          train_q;
  logic          train_d;
  logic [MW-1:0] match_cnt;
  logic [TW-1:0] time_cnt;
  logic          cand;

  logic train_rise;
  logic is_norm;
  logic is_swap;
  logic hit;
  logic same;
  logic lock_now;
  logic timeout_now;

  // train is a level from the host: one register stage samples it, a second
  // holds the previous sample, so only a 0->1 transition acts (on the next edge).
  assign train_rise = train_q & ~train_d;

  assign is_norm     = (bus.din_rise == PAT_A) && (bus.din_fall == PAT_B);
  assign is_swap     = (bus.din_rise == PAT_B) && (bus.din_fall == PAT_A);
  assign hit         = is_norm | is_swap;
  // Same orientation as the current candidate and a run already in progress.
  assign same        = hit && (match_cnt != '0) && (is_swap == cand);
  assign lock_now    = same && (match_cnt == MW'(LOCK_COUNT - 1));
  assign timeout_now = (time_cnt == TW'(TIMEOUT - 1));

  // Sample the host train level and keep its previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_q <= 1'b0;
      train_d <= 1'b0;
    end else begin
      train_q <= bus.train;
      train_d <= train_q;
    end
  end

  // Training/lock state machine and the registered A/B output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      match_cnt      <= '0;
      time_cnt       <= '0;
      cand           <= 1'b0;
      bus.dout_a     <= '0;
      bus.dout_b     <= '0;
      bus.dout_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.swapped    <= 1'b0;
      bus.train_fail <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      bus.dout_valid <= 1'b0;
      if (train_rise) begin
        state          <= TRAIN;
        match_cnt      <= '0;
        time_cnt       <= '0;
        cand           <= 1'b0;
        bus.locked     <= 1'b0;
        bus.swapped    <= 1'b0;
        bus.train_fail <= 1'b0;
        bus.err_count  <= '0;
      end else begin
        case (state)
          TRAIN: begin
            time_cnt <= time_cnt + 1'b1;
            if (!hit) begin
              match_cnt <= '0;
              if (bus.err_count != 16'hFFFF) bus.err_count <= bus.err_count + 1'b1;
            end else if (same) begin
              match_cnt <= match_cnt + 1'b1;
            end else begin
              cand      <= is_swap;
              match_cnt <= MW'(1);
            end
            // A lock on the final allowed cycle still wins over the timeout.
            if (lock_now) begin
              state       <= LOCKED;
              bus.locked  <= 1'b1;
              bus.swapped <= cand;
            end else if (timeout_now) begin
              state          <= FAIL;
              bus.train_fail <= 1'b1;
            end
          end
          LOCKED: begin
            bus.dout_a     <= bus.swapped ? bus.din_fall : bus.din_rise;
            bus.dout_b     <= bus.swapped ? bus.din_rise : bus.din_fall;
            bus.dout_valid <= 1'b1;
          end
          default: begin
            // IDLE and FAIL hold outputs until reset or a new train edge.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9643_ddr_deinterleave.sv
// Testbench for ad9643_ddr_deinterleave: table-driven training scenarios,
// hand sequences for timeout and asynchronous reset, randomized training runs
// checked against a run-length reference model of the lock rules.
module tb_ad9643_ddr_deinterleave;

  localparam int          W  = 14;
  localparam logic [13:0] PA = 14'h2AAA;
  localparam logic [13:0] PB = 14'h1555;
  localparam int          LC = 64;
  localparam int          TO = 4096;

  typedef struct packed {
    logic [13:0] r;
    logic [13:0] f;
  } pair_t;
  typedef pair_t pairq_t[$];

  typedef struct {
    bit pre_o;
    int pre_n;
    int gap_n;
    bit post_o;
    int lk;
    int err;
    bit swp;
    bit hold;
  } scen_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [13:0] last_a = '0;
  logic [13:0] last_b = '0;
  scen_t tbl[4];

  ad9643_ddr_deinterleave_if #(.W(W)) bus ();

  ad9643_ddr_deinterleave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic [63:0] outs();
    return {16'h0, bus.dout_a, bus.dout_b, bus.dout_valid, bus.locked,
            bus.swapped, bus.train_fail, bus.err_count};
  endfunction

  function automatic pair_t pat(input bit o);
    pair_t p;
    p.r = o ? PB : PA;
    p.f = o ? PA : PB;
    return p;
  endfunction

  function automatic pair_t bad();
    pair_t p;
    p.r = 14'($urandom);
    if (p.r == PA || p.r == PB) p.r = 14'h0;
    p.f = 14'($urandom);
    return p;
  endfunction

  task automatic drive(input pair_t p);
    bus.din_rise = p.r;
    bus.din_fall = p.f;
  endtask

  // 0 = normal orientation, 1 = swapped, 2 = no pattern
  function automatic int cls(input pair_t p);
    if (p.r == PA && p.f == PB) return 0;
    if (p.r == PB && p.f == PA) return 1;
    return 2;
  endfunction

  // Lock happens at the first entry that closes a window of LC identical
  // orientations; errors are the no-pattern entries up to that point.
  function automatic void ref_model(input pairq_t s, output int lk, output int errs,
                                    output bit swp);
    bit run;
    lk = -1;
    errs = 0;
    swp = 1'b0;
    for (int i = 0; i < s.size() && i < TO; i++) begin
      if (cls(s[i]) == 2) begin
        errs++;
      end else if (i >= LC - 1) begin
        run = 1'b1;
        for (int j = i - LC + 1; j < i; j++)
          if (cls(s[j]) != cls(s[i])) run = 1'b0;
        if (run) begin
          lk = i;
          swp = (cls(s[i]) == 1);
          return;
        end
      end
    end
  endfunction

  function automatic pairq_t build(input scen_t c);
    pairq_t s;
    s = {};
    for (int i = 0; i < c.pre_n; i++) s.push_back(pat(c.pre_o));
    for (int i = 0; i < c.gap_n; i++) s.push_back(bad());
    for (int i = 0; i < LC + 6; i++) s.push_back(pat(c.post_o));
    return s;
  endfunction

  // Pulse train, feed the training stream up to the expected lock (or timeout)
  // entry, then check status and either the locked data path or the FAIL hold.
  task automatic run_check(input pairq_t s, input int lk, input int ex_err,
                           input bit ex_swp, input bit hold, input string nm);
    int    last;
    pair_t p;
    bus.train = 1'b0;
    tick();
    tick();
    bus.train = 1'b1;
    tick();
    tick();
    chk({nm, "_entry_vld"}, 64'(bus.dout_valid), 64'd0);
    chk({nm, "_entry_err"}, 64'(bus.err_count), 64'd0);
    chk({nm, "_entry_flags"}, 64'({bus.locked, bus.train_fail, bus.swapped}), 64'd0);
    if (!hold) bus.train = 1'b0;
    last = (lk < 0) ? TO - 1 : lk;
    for (int i = 0; i <= last; i++) begin
      drive(s[i]);
      tick();
      if (i == last - 1)
        chk({nm, "_prelock"}, 64'({bus.locked, bus.train_fail, bus.dout_valid}), 64'd0);
    end
    if (lk >= 0) begin
      chk({nm, "_locked"}, 64'(bus.locked), 64'd1);
      chk({nm, "_swapped"}, 64'(bus.swapped), 64'(ex_swp));
      chk({nm, "_nofail"}, 64'(bus.train_fail), 64'd0);
      chk({nm, "_err"}, 64'(bus.err_count), 64'(ex_err));
      chk({nm, "_vld_lockcyc"}, 64'(bus.dout_valid), 64'd0);
      for (int n = 0; n < 16; n++) begin
        if (n < 8) begin
          p.r = 14'(n);
          p.f = 14'(n + 'h100);
        end else begin
          p.r = 14'($urandom);
          p.f = 14'($urandom);
        end
        drive(p);
        tick();
        last_a = ex_swp ? p.f : p.r;
        last_b = ex_swp ? p.r : p.f;
        chk({nm, "_data_vld"}, 64'(bus.dout_valid), 64'd1);
        chk({nm, "_data_ab"}, 64'({bus.dout_a, bus.dout_b}), 64'({last_a, last_b}));
      end
    end else begin
      chk({nm, "_train_fail"}, 64'(bus.train_fail), 64'd1);
      chk({nm, "_fail_locked"}, 64'(bus.locked), 64'd0);
      chk({nm, "_fail_vld"}, 64'(bus.dout_valid), 64'd0);
      chk({nm, "_fail_err"}, 64'(bus.err_count), 64'(ex_err));
      for (int n = 0; n < 5; n++) begin
        drive(pat(1'b0));
        tick();
        chk({nm, "_fail_hold"},
            64'({bus.dout_valid, bus.train_fail, bus.locked, bus.err_count, bus.dout_a, bus.dout_b}),
            64'({1'b0, 1'b1, 1'b0, 16'(ex_err), last_a, last_b}));
      end
    end
  endtask

  task automatic async_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    chk({nm, "_async_clear"}, outs(), 64'd0);
    last_a = '0;
    last_b = '0;
    bus.train = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    pairq_t s;
    int     lk;
    int     er;
    bit     sw;

    tbl[0] = '{pre_o: 1'b0, pre_n: 0,  gap_n: 0, post_o: 1'b0, lk: 63,  err: 0, swp: 1'b0, hold: 1'b0};
    tbl[1] = '{pre_o: 1'b1, pre_n: 30, gap_n: 3, post_o: 1'b1, lk: 96,  err: 3, swp: 1'b1, hold: 1'b1};
    tbl[2] = '{pre_o: 1'b0, pre_n: 40, gap_n: 0, post_o: 1'b1, lk: 103, err: 0, swp: 1'b1, hold: 1'b0};
    tbl[3] = '{pre_o: 1'b0, pre_n: 63, gap_n: 1, post_o: 1'b0, lk: 127, err: 1, swp: 1'b0, hold: 1'b1};

    rst_n = 1'b0;
    bus.din_rise = '0;
    bus.din_fall = '0;
    bus.train = 1'b0;
    tick();
    tick();
    tick();
    chk("reset_state", outs(), 64'd0);
    rst_n = 1'b1;

    // Idle: random words with train low leave everything at zero.
    for (int i = 0; i < 100; i++) begin
      bus.din_rise = 14'($urandom);
      bus.din_fall = 14'($urandom);
      tick();
      chk("idle_outputs", outs(), 64'd0);
    end

    for (int t = 0; t < 4; t++)
      run_check(build(tbl[t]), tbl[t].lk, tbl[t].err, tbl[t].swp, tbl[t].hold,
                $sformatf("tbl%0d", t));

    async_reset("midlocked");

    // Constant zero data never matches: fail exactly at the timeout.
    s = {};
    for (int i = 0; i < TO; i++) s.push_back(pair_t'(28'h0));
    run_check(s, -1, TO, 1'b0, 1'b0, "timeout");
    run_check(build(tbl[0]), tbl[0].lk, tbl[0].err, tbl[0].swp, 1'b0, "after_fail");

    // Reset in the middle of training, after some errors were counted.
    bus.train = 1'b0;
    tick();
    tick();
    bus.train = 1'b1;
    tick();
    tick();
    bus.train = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(bad());
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(pat(1'b0));
      tick();
    end
    chk("midtrain_err", 64'(bus.err_count), 64'd5);
    async_reset("midtrain");
    run_check(build(tbl[1]), tbl[1].lk, tbl[1].err, tbl[1].swp, 1'b0, "after_rst");

    // Randomized noise prefix followed by a clean run of random orientation.
    for (int t = 0; t < 4; t++) begin
      int n;
      bit o;
      s = {};
      n = $urandom_range(0, 60);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0:       s.push_back(pat(1'b0));
          1:       s.push_back(pat(1'b1));
          default: s.push_back(bad());
        endcase
      end
      o = 1'($urandom_range(0, 1));
      for (int k = 0; k < LC + 2; k++) s.push_back(pat(o));
      ref_model(s, lk, er, sw);
      run_check(s, lk, er, sw, 1'(t & 1), $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9643_ddr_deinterleave.md
# ad9643_ddr_deinterleave

Splits the interleaved DDR sample stream of the AD9643 into channel A and channel B words, directly downstream of the LVDS input buffer stage and the DDR capture registers. During a host-triggered training phase it checks a known ADC test pattern and decides whether rise and fall words are swapped. It then locks and emits aligned A/B sample pairs with a valid strobe. Training failures are flagged, and a mismatch count is kept for the host.

## Interface
- W, 14: ADC sample width (data lane count).
- PAT_A, 14'h2AAA: training pattern the ADC drives on channel A while in test mode.
- PAT_B, 14'h1555: training pattern on channel B; must differ from PAT_A.
- LOCK_COUNT, 64: consecutive same-orientation matches required to lock (≥2).
- TIMEOUT, 4096: maximum TRAIN cycles before failure (> LOCK_COUNT).

Ports:
- clk  in  1  ADC data clock (buffered DCO); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din_rise  in  W  word captured on DCO rising edge.
- din_fall  in  W  word captured on DCO falling edge, same cycle.
- train  in  1  level from host; a rising edge starts or restarts training.
- dout_a  out  W  channel A sample, registered.
- dout_b  out  W  channel B sample, registered.
- dout_valid  out  1  dout_a/dout_b hold a new aligned pair this cycle.
- locked  out  1  alignment decided; stream valid.
- swapped  out  1  decided orientation (1 = A arrives on fall edge).
- train_fail  out  1  last training attempt timed out.
- err_count  out  16  mismatch cycles in current/last training, saturates at 16'hFFFF.

## Operation
- States: IDLE, TRAIN, LOCKED, FAIL. Reset enters IDLE.
- The train rising edge is detected through a registered copy of train (train_d), so only a 0→1 transition counts.
- A train rising edge in any state does the following on the next edge:
  - enters TRAIN;
  - clears the match counter, timeout counter, err_count, locked, train_fail and swapped;
  - clears the candidate orientation `cand`.
- Per TRAIN cycle, classify the inputs:
  - norm: din_rise==PAT_A and din_fall==PAT_B.
  - swap: din_rise==PAT_B and din_fall==PAT_A.
  - otherwise: mismatch.
- Match counter behaviour:
  - norm/swap equal to `cand` and counter nonzero: counter +1.
  - norm/swap differing from `cand`, or counter zero: `cand` ← orientation, counter ← 1.
  - mismatch: counter ← 0, err_count +1 (saturating).
- Lock: when the counter would reach LOCK_COUNT, the next state is LOCKED. locked←1 and swapped←`cand`.
- Timeout counter increments every TRAIN cycle. If it equals TIMEOUT-1 and no lock occurs that cycle, the next state is FAIL and train_fail←1.
- Lock takes priority over timeout in the same cycle.
- LOCKED behaviour:
  - each cycle: dout_a←swapped ? din_fall : din_rise; dout_b←the other word; dout_valid←1.
  - stays in LOCKED until reset or a train rising edge. Data content is not checked after lock.
- IDLE and FAIL: dout_valid=0. dout_a/dout_b hold their last value. FAIL holds until a train rising edge.
- err_count and swapped hold after leaving TRAIN, for host readback.

## Timing
- Reset values: dout_a=0, dout_b=0, dout_valid=0, locked=0, swapped=0, train_fail=0, err_count=0. State is IDLE.
- Reset is asserted asynchronously at any time, including mid-TRAIN or mid-LOCKED. Outputs clear immediately.
- Train edge detection:
  - train high at edge k, low at k-1: state is TRAIN after edge k+1.
  - dout_valid is 0 from edge k+1.
- Lock timing:
  - first TRAIN compare cycle is the cycle after entry. With LOCK_COUNT clean matches, locked rises at the edge after the LOCK_COUNT-th match.
  - dout_valid first rises one edge after locked, carrying the inputs sampled in the first LOCKED cycle.
- Data latency in LOCKED: 1 cycle, input pair to dout.
- Timeout: with no lock, train_fail rises exactly TIMEOUT edges after TRAIN entry.
- A train edge arriving while held high does not retrigger.

## Test plan
- Reset, then 100 cycles of random input with train=0 → all outputs 0, state IDLE.
- Train pulse, rise=0x2AAA, fall=0x1555 for 64 cycles, then ramp data rise=n, fall=n+0x100 → locked=1, swapped=0, err_count=0, dout_a=n, dout_b=n+0x100 one cycle later, dout_valid continuous.
- Train pulse, rise=0x1555, fall=0x2AAA, with 3 random mismatch cycles inserted after match 30 → locked after 64 further clean matches, swapped=1, err_count=3, dout_a takes the fall word.
- Train pulse, orientation flips norm→swap at match 40 → counter restarts, locks 64 matches after the flip, swapped=1.
- Train pulse with constant 0x0000 → train_fail=1 at 4096 cycles, err_count=4096, locked=0, dout_valid=0; a second train pulse with correct pattern then locks and clears train_fail.
- Assert rst_n low mid-LOCKED and mid-TRAIN → outputs 0 without waiting for clk; a train pulse after release locks normally.
